// File: rtl/seq_sub_unit_if.sv
// Operand/result handshake bundle for seq_sub_unit.
// Flag signals exist only when SUB_FLAGS_EN is defined.
interface seq_sub_unit_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bout;
`ifdef SUB_FLAGS_EN
  logic       ovf;
  logic       zero;
  logic       neg;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero, neg
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero, neg
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
  );
`endif
endinterface

// File: rtl/seq_sub_unit.sv
// Nibble-serial 8-bit subtractor (a - b - bin) using a 4-bit carry-lookahead stage.
// Optional macro SUB_FLAGS_EN adds registered ovf/zero/neg status outputs.
module seq_sub_unit (
  input  logic          clk,
  input  logic          rst_n,
  seq_sub_unit_if.slave bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // 4-bit carry-lookahead adder; returns {carry_out, sum}.
  function automatic logic [NW:0] cla4(input logic [NW-1:0] x,
                                       input logic [NW-1:0] y,
                                       input logic           cin);
    logic [NW-1:0] g;
    logic [NW-1:0] p;
    logic [NW:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[NW], p ^ c[NW-1:0]};
  endfunction

  logic [1:0]    r_state;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic          r_bin;
  logic          r_c4;
  logic [DW-1:0] r_d;
  logic          r_bout;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_a_nxt;
  logic [DW-1:0] w_b_nxt;
  logic          w_bin_nxt;
  logic          w_c4_nxt;
  logic [DW-1:0] w_d_nxt;
  logic          w_bout_nxt;
  logic          w_in_ready_nxt;
  logic          w_out_valid_nxt;

  logic [NW:0]   w_low;
  logic [NW:0]   w_high;

`ifdef SUB_FLAGS_EN
  logic          r_ovf;
  logic          r_zero;
  logic          r_neg;
  logic          w_ovf_nxt;
  logic          w_zero_nxt;
  logic          w_neg_nxt;
`endif

  // Subtraction as a + ~b + ~bin; borrow is the inverted final carry.
  assign w_low  = cla4(r_a[NW-1:0],  ~r_b[NW-1:0],  ~r_bin);
  assign w_high = cla4(r_a[DW-1:NW], ~r_b[DW-1:NW], r_c4);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_bin_nxt   = r_bin;
    w_c4_nxt    = r_c4;
    w_d_nxt     = r_d;
    w_bout_nxt  = r_bout;
`ifdef SUB_FLAGS_EN
    w_ovf_nxt   = r_ovf;
    w_zero_nxt  = r_zero;
    w_neg_nxt   = r_neg;
`endif

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_a_nxt     = bus.a;
          w_b_nxt     = bus.b;
          w_bin_nxt   = bus.bin;
          w_state_nxt = LOW;
        end
      end
      LOW: begin
        w_d_nxt[NW-1:0] = w_low[NW-1:0];
        w_c4_nxt        = w_low[NW];
        w_state_nxt     = HIGH;
      end
      HIGH: begin
        w_d_nxt[DW-1:NW] = w_high[NW-1:0];
        w_bout_nxt       = ~w_high[NW];
`ifdef SUB_FLAGS_EN
        w_ovf_nxt  = (r_a[DW-1] ^ r_b[DW-1]) & (w_high[NW-1] ^ r_a[DW-1]);
        w_zero_nxt = ({w_high[NW-1:0], r_d[NW-1:0]} == 8'd0);
        w_neg_nxt  = w_high[NW-1];
`endif
        w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_out_valid_nxt = (w_state_nxt == DONE);
  end

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bin       <= 1'b0;
      r_c4        <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SUB_FLAGS_EN
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_bin       <= w_bin_nxt;
      r_c4        <= w_c4_nxt;
      r_d         <= w_d_nxt;
      r_bout      <= w_bout_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifdef SUB_FLAGS_EN
      r_ovf       <= w_ovf_nxt;
      r_zero      <= w_zero_nxt;
      r_neg       <= w_neg_nxt;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.d         = r_d;
  assign bus.bout      = r_bout;
`ifdef SUB_FLAGS_EN
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
`endif

endmodule
